// File: rtl/term_input_arbiter.sv
// Arbitrates two byte sources onto the termbuffer input, one byte in flight, with escape-sequence locking.
// Optional build macro TERM_ARB_FIXED_PRI_EN: unlocked ties always go to source A instead of round-robin.
module term_input_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SEQ_MAX        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_byte,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_byte,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] tb_byte,
  output logic       tb_byte_v,
  input  logic       tb_done,
  output logic       grant_a,
  output logic       grant_b,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_seq
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(SEQ_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(SEQ_MAX);
`ifdef TERM_ARB_FIXED_PRI_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;
  typedef enum logic [1:0] {SEQ_NONE, SEQ_ESC, SEQ_CSI} seq_e;

  state_e        state_q;
  seq_e          seq_q;
  logic          lock_a_q, lock_b_q;
  logic          last_b_q;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] len_q;
  logic [7:0]    byte_q;
  logic          byte_v_q, err_to_q, err_seq_q;

  logic          locked, elig_a, elig_b, pick_a, pick_b, accept;
  logic [7:0]    acc_byte;
  seq_e          seq_d;
  logic [LW-1:0] len_d, len_inc;
  logic          err_seq_d;

  // While locked only the holder may be served; otherwise ties alternate (or favour A).
  always_comb begin
    locked = lock_a_q | lock_b_q;
    elig_a = a_valid && (!locked || lock_a_q);
    elig_b = b_valid && (!locked || lock_b_q);
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (state_q == IDLE) begin
      if (elig_a && elig_b) begin
        pick_a = FIXED_PRI || last_b_q;
        pick_b = !pick_a;
      end else begin
        pick_a = elig_a;
        pick_b = elig_b;
      end
    end
    accept   = pick_a | pick_b;
    acc_byte = pick_a ? a_byte : b_byte;
  end

  always_comb begin
    seq_d     = seq_q;
    len_d     = len_q;
    err_seq_d = 1'b0;
    len_inc   = (len_q < LEN_MAX) ? len_q + LW'(1) : len_q;
    if (acc_byte == 8'h1B) begin
      seq_d = SEQ_ESC;
      len_d = LW'(1);
    end else begin
      case (seq_q)
        SEQ_ESC: begin
          if (acc_byte == 8'h5B) begin
            seq_d = SEQ_CSI;
            len_d = len_inc;
          end else begin
            seq_d = SEQ_NONE;
          end
        end
        SEQ_CSI: begin
          if (acc_byte >= 8'h40 && acc_byte <= 8'h7E) seq_d = SEQ_NONE;
          else len_d = len_inc;
        end
        default: ;
      endcase
    end
    // An over-long sequence is cut short; its lock drops when this byte completes.
    if (seq_d != SEQ_NONE && len_d >= LEN_MAX) begin
      err_seq_d = 1'b1;
      seq_d     = SEQ_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      seq_q     <= SEQ_NONE;
      lock_a_q  <= 1'b0;
      lock_b_q  <= 1'b0;
      last_b_q  <= 1'b1;
      cnt_q     <= '0;
      len_q     <= '0;
      byte_q    <= '0;
      byte_v_q  <= 1'b0;
      err_to_q  <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      byte_v_q  <= 1'b0;
      err_to_q  <= 1'b0;
      err_seq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= ISSUE;
            byte_q    <= acc_byte;
            byte_v_q  <= 1'b1;
            last_b_q  <= pick_b;
            seq_q     <= seq_d;
            len_q     <= len_d;
            err_seq_q <= err_seq_d;
            cnt_q     <= '0;
            if (acc_byte == 8'h1B) begin
              lock_a_q <= pick_a;
              lock_b_q <= pick_b;
            end
          end else if (locked) begin
            if (cnt_q == CNT_LAST) begin
              err_to_q <= 1'b1;
              lock_a_q <= 1'b0;
              lock_b_q <= 1'b0;
              seq_q    <= SEQ_NONE;
              len_q    <= '0;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        ISSUE: begin
          state_q <= WAIT_DONE;
          cnt_q   <= '0;
        end
        WAIT_DONE: begin
          if (tb_done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            if (seq_q == SEQ_NONE) begin
              lock_a_q <= 1'b0;
              lock_b_q <= 1'b0;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= IDLE;
            err_to_q <= 1'b1;
            lock_a_q <= 1'b0;
            lock_b_q <= 1'b0;
            seq_q    <= SEQ_NONE;
            len_q    <= '0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ready     = pick_a;
  assign b_ready     = pick_b;
  assign tb_byte     = byte_q;
  assign tb_byte_v   = byte_v_q;
  assign grant_a     = lock_a_q;
  assign grant_b     = lock_b_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_to_q;
  assign err_seq     = err_seq_q;

endmodule

// File: tb/tb_term_input_arbiter.sv
// Directed testbench for term_input_arbiter (TIMEOUT_CYCLES=16, SEQ_MAX=4); honours TERM_ARB_FIXED_PRI_EN.
module tb_term_input_arbiter;

`ifdef TERM_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] a_byte = 8'h00, b_byte = 8'h00;
  logic       a_valid = 1'b0, b_valid = 1'b0, tb_done = 1'b0;
  logic       a_ready, b_ready, tb_byte_v, grant_a, grant_b, busy, err_timeout, err_seq;
  logic [7:0] tb_byte;
  int         vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  term_input_arbiter #(.TIMEOUT_CYCLES(16), .SEQ_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .a_byte(a_byte), .a_valid(a_valid), .a_ready(a_ready),
    .b_byte(b_byte), .b_valid(b_valid), .b_ready(b_ready),
    .tb_byte(tb_byte), .tb_byte_v(tb_byte_v), .tb_done(tb_done),
    .grant_a(grant_a), .grant_b(grant_b), .busy(busy),
    .err_timeout(err_timeout), .err_seq(err_seq)
  );

  // Bit order: a_ready b_ready tb_byte_v busy grant_a grant_b err_timeout err_seq
  function automatic logic [7:0] flags();
    return {a_ready, b_ready, tb_byte_v, busy, grant_a, grant_b, err_timeout, err_seq};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tb_done = 1'b0;
    rst     = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Moves from the ISSUE cycle through WAIT_DONE, answering done two cycles after the pulse.
  task automatic complete_xfer();
    step();
    step();
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    vectors++;
    if (flags() !== 8'b0000_0000 || tb_byte !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: flags=%b tb_byte=%h, want flags=00000000 tb_byte=00", flags(), tb_byte);
    end
  endtask

  task automatic test_single_byte();
    do_reset();
    a_byte  = 8'h6C;
    a_valid = 1'b1;
    sample();
    vectors++;
    if (flags() !== 8'b1000_0000) begin
      miscompares++;
      $display("[TB] FAIL single_accept: flags=%b, want 10000000", flags());
    end
    step();
    a_valid = 1'b0;
    sample();
    vectors++;
    if (flags() !== 8'b0011_0000 || tb_byte !== 8'h6C) begin
      miscompares++;
      $display("[TB] FAIL single_issue: flags=%b tb_byte=%h, want 00110000 6c", flags(), tb_byte);
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      sample();
      vectors++;
      if (flags() !== 8'b0001_0000) begin
        miscompares++;
        $display("[TB] FAIL single_wait_c%0d: flags=%b, want 00010000", c, flags());
      end
    end
    step();
    tb_done = 1'b1;
    sample();
    vectors++;
    if (flags() !== 8'b0001_0000) begin
      miscompares++;
      $display("[TB] FAIL single_done_cycle: flags=%b, want 00010000", flags());
    end
    step();
    tb_done = 1'b0;
    sample();
    vectors++;
    if (flags() !== 8'b0000_0000 || tb_byte !== 8'h6C) begin
      miscompares++;
      $display("[TB] FAIL single_idle: flags=%b tb_byte=%h, want 00000000 6c", flags(), tb_byte);
    end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    do_reset();
    a_byte  = 8'h41;
    b_byte  = 8'h62;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_a = FIXED ? 1'b1 : (i % 2 == 0);
      sample();
      vectors++;
      if ({a_ready, b_ready} !== {exp_a, !exp_a}) begin
        miscompares++;
        $display("[TB] FAIL rr_pick%0d: ready=%b%b, want %b%b", i, a_ready, b_ready, exp_a, !exp_a);
      end
      step();
      sample();
      vectors++;
      if (tb_byte_v !== 1'b1 || tb_byte !== (exp_a ? 8'h41 : 8'h62)) begin
        miscompares++;
        $display("[TB] FAIL rr_byte%0d: v=%b byte=%h, want 1 %h", i, tb_byte_v, tb_byte, exp_a ? 8'h41 : 8'h62);
      end
      complete_xfer();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_escape_lock();
    logic [7:0] s [4];
    s = '{8'h1B, 8'h5B, 8'h32, 8'h4A};
    do_reset();
    b_byte  = 8'h62;
    b_valid = 1'b1;
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_byte = s[i];
      sample();
      vectors++;
      if ({a_ready, b_ready} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL lock_pick%0d: ready=%b%b, want 10", i, a_ready, b_ready);
      end
      step();
      if (i == 3) a_valid = 1'b0;
      sample();
      vectors++;
      if (flags() !== 8'b0011_1000 || tb_byte !== s[i]) begin
        miscompares++;
        $display("[TB] FAIL lock_issue%0d: flags=%b byte=%h, want 00111000 %h", i, flags(), tb_byte, s[i]);
      end
      complete_xfer();
    end
    sample();
    vectors++;
    if (flags() !== 8'b0100_0000) begin
      miscompares++;
      $display("[TB] FAIL lock_release: flags=%b, want 01000000", flags());
    end
    step();
    b_valid = 1'b0;
    sample();
    vectors++;
    if (tb_byte !== 8'h62 || tb_byte_v !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lock_b_after: v=%b byte=%h, want 1 62", tb_byte_v, tb_byte);
    end
  endtask

  task automatic test_done_timeout();
    do_reset();
    a_byte  = 8'h41;
    a_valid = 1'b1;
    sample();
    step();
    a_valid = 1'b0;
    step();
    for (int j = 0; j < 16; j++) begin
      sample();
      vectors++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL tmo_wait%0d: err=%b busy=%b, want 0 1", j, err_timeout, busy);
      end
      step();
    end
    sample();
    vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL tmo_pulse: err_timeout=%b, want 1", err_timeout);
    end
    step();
    sample();
    vectors++;
    if (flags() !== 8'b0000_0000) begin
      miscompares++;
      $display("[TB] FAIL tmo_idle: flags=%b, want 00000000", flags());
    end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    a_byte  = 8'h1B;
    a_valid = 1'b1;
    b_byte  = 8'h62;
    sample();
    step();
    a_valid = 1'b0;
    b_valid = 1'b1;
    complete_xfer();
    for (int j = 0; j < 16; j++) begin
      sample();
      vectors++;
      if (flags() !== 8'b0000_1000) begin
        miscompares++;
        $display("[TB] FAIL lockidle_hold%0d: flags=%b, want 00001000", j, flags());
      end
      step();
    end
    sample();
    vectors++;
    if (flags() !== 8'b0100_0010) begin
      miscompares++;
      $display("[TB] FAIL lockidle_expire: flags=%b, want 01000010", flags());
    end
    b_valid = 1'b0;
  endtask

  task automatic test_seq_max();
    logic [7:0] s [4];
    logic exp_a;
    s = '{8'h1B, 8'h5B, 8'h31, 8'h32};
    do_reset();
    b_byte  = 8'h62;
    b_valid = 1'b1;
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_byte = s[i];
      sample();
      vectors++;
      if ({a_ready, b_ready} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL seq_pick%0d: ready=%b%b, want 10", i, a_ready, b_ready);
      end
      step();
      sample();
      vectors++;
      if (flags() !== {7'b0011_100, i == 3} || tb_byte !== s[i]) begin
        miscompares++;
        $display("[TB] FAIL seq_issue%0d: flags=%b byte=%h, want %b %h", i, flags(), tb_byte, {7'b0011_100, i == 3}, s[i]);
      end
      complete_xfer();
    end
    a_byte = 8'h33;
    exp_a  = FIXED;
    sample();
    vectors++;
    if (flags() !== {exp_a, !exp_a, 6'b00_0000}) begin
      miscompares++;
      $display("[TB] FAIL seq_release: flags=%b, want %b", flags(), {exp_a, !exp_a, 6'b00_0000});
    end
    step();
    if (exp_a) a_valid = 1'b0;
    else b_valid = 1'b0;
    sample();
    vectors++;
    if (tb_byte !== (exp_a ? 8'h33 : 8'h62)) begin
      miscompares++;
      $display("[TB] FAIL seq_first_after: byte=%h, want %h", tb_byte, exp_a ? 8'h33 : 8'h62);
    end
    complete_xfer();
    sample();
    vectors++;
    if ({a_ready, b_ready} !== {!exp_a, exp_a}) begin
      miscompares++;
      $display("[TB] FAIL seq_second_after: ready=%b%b, want %b%b", a_ready, b_ready, !exp_a, exp_a);
    end
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    sample();
    vectors++;
    if (tb_byte !== (exp_a ? 8'h62 : 8'h33)) begin
      miscompares++;
      $display("[TB] FAIL seq_second_byte: byte=%h, want %h", tb_byte, exp_a ? 8'h62 : 8'h33);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    a_byte  = 8'h1B;
    a_valid = 1'b1;
    sample();
    step();
    a_valid = 1'b0;
    step();
    sample();
    vectors++;
    if (flags() !== 8'b0001_1000) begin
      miscompares++;
      $display("[TB] FAIL midrst_before: flags=%b, want 00011000", flags());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    vectors++;
    if (flags() !== 8'b0000_0000 || tb_byte !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midrst_after: flags=%b byte=%h, want 00000000 00", flags(), tb_byte);
    end
    step();
    sample();
    vectors++;
    if (flags() !== 8'b0000_0000) begin
      miscompares++;
      $display("[TB] FAIL midrst_quiet: flags=%b, want 00000000", flags());
    end
    step();
    a_byte  = 8'h41;
    b_byte  = 8'h62;
    a_valid = 1'b1;
    b_valid = 1'b1;
    sample();
    vectors++;
    if ({a_ready, b_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL midrst_first: ready=%b%b, want 10", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    sample();
    vectors++;
    if (tb_byte !== 8'h41 || grant_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_byte: byte=%h grant_a=%b, want 41 0", tb_byte, grant_a);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_escape_lock();
    test_done_timeout();
    test_lock_timeout();
    test_seq_max();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
